iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_muldiv.sv | 112 +++++++++++
 rtl/iter_alu.sv | 137 +++++++++++++
 tb/tb_iter_alu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU.
//   ALU_WIDTH : default operand/result width
//   OP_*      : 4-bit opcode encodings (1101-1111 are undefined)
//   state_t   : controller states
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative multiplier (shift-add, low WIDTH bits) and, when ITER_ALU_DIV_EN
// is defined, restoring divider (signed/unsigned). One iteration per clock,
// exactly WIDTH iterations per operation.
//   clk, rst_n      : clock, async active-low reset
//   start           : load operands and begin (one cycle pulse)
//   kill            : abandon any operation in flight
//   div_op          : (ITER_ALU_DIV_EN only) operation is a divide
//   div_signed      : (ITER_ALU_DIV_EN only) signed divide
//   a, b            : operands
//   done            : high during the final iteration cycle
//   res             : final result, valid while done is high
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
`ifdef ITER_ALU_DIV_EN
  input  logic             div_op,
  input  logic             div_signed,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH);

  logic          busy;
  logic [CW-1:0] cnt;
  logic          last;

  logic [WIDTH-1:0] acc, mcand, mplr;
  logic [WIDTH-1:0] acc_nxt;

  // Down-counter loaded with WIDTH-1; terminal count marks the last iteration.
  assign last    = busy && (cnt == '0);
  assign done    = last;
  assign acc_nxt = mplr[0] ? (acc + mcand) : acc;

`ifdef ITER_ALU_DIV_EN
  logic             is_div, neg, dz;
  logic [WIDTH:0]   rem, rem_sh, diff, rem_nxt;
  logic [WIDTH-1:0] quo, dvsr, quo_nxt, a_mag, b_mag, div_q;
  logic             ge;

  // Signed divide runs on magnitudes; the sign is reapplied at the end.
  // The most-negative / -1 case falls out as 2^(WIDTH-1) negated, i.e. itself.
  assign a_mag   = (div_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag   = (div_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dvsr};
  assign ge      = ~diff[WIDTH];
  assign rem_nxt = ge ? diff : rem_sh;
  assign quo_nxt = {quo[WIDTH-2:0], ge};
  // Divide by zero must give all ones regardless of dividend sign.
  assign div_q   = dz  ? '1 : (neg ? (~quo_nxt + WIDTH'(1)) : quo_nxt);
  assign res     = is_div ? div_q : acc_nxt;
`else
  assign res     = acc_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
`ifdef ITER_ALU_DIV_EN
      is_div <= 1'b0;
      neg    <= 1'b0;
      dz     <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
`endif
    end else if (kill) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CW'(WIDTH-1);
      acc   <= '0;
      mcand <= a;
      mplr  <= b;
`ifdef ITER_ALU_DIV_EN
      is_div <= div_op;
      neg    <= div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      dz     <= (b == '0);
      rem    <= '0;
      quo    <= a_mag;
      dvsr   <= b_mag;
`endif
    end else if (busy) begin
      acc   <= acc_nxt;
      mcand <= {mcand[WIDTH-2:0], 1'b0};
      mplr  <= {1'b0, mplr[WIDTH-1:1]};
      cnt   <= cnt - CW'(1);
      if (last) busy <= 1'b0;
`ifdef ITER_ALU_DIV_EN
      rem <= rem_nxt;
      quo <= quo_nxt;
`endif
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU with valid/ready handshakes on request and result.
// Logic/shift/add/compare ops finish in one cycle; MUL (and DIV/DIVU when
// ITER_ALU_DIV_EN is defined) take WIDTH iterations in alu_muldiv.
// Without ITER_ALU_DIV_EN, DIV/DIVU behave as undefined opcodes.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : request handshake
//   select, data1, data2  : opcode and operands, captured on accept
//   flush                 : synchronous abort, highest priority
//   out_valid / out_ready : result handshake
//   result, err           : registered result and undefined-opcode flag
//
// state  | meaning
// S_IDLE | waiting for a request, in_ready high
// S_BUSY | multi-cycle operation iterating in alu_muldiv
// S_DONE | result presented, waiting for out_ready
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
    $error("iter_alu: WIDTH must be a power of two, at least 8");
  end

  state_t           state;
  logic [WIDTH-1:0] op_res, md_res;
  logic             op_err, op_multi, md_done, accept;
  logic [SHW-1:0]   shamt;

  assign shamt  = data2[SHW-1:0];
  assign accept = in_valid && in_ready && !flush;

  always_comb begin
    op_res   = '0;
    op_err   = 1'b0;
    op_multi = 1'b0;
    case (select)
      OP_AND:  op_res = data1 & data2;
      OP_OR:   op_res = data1 | data2;
      OP_ADD:  op_res = data1 + data2;
      OP_XOR:  op_res = data1 ^ data2;
      OP_SLL:  op_res = data1 << shamt;
      OP_SRL:  op_res = data1 >> shamt;
      OP_SUB:  op_res = data1 - data2;
      OP_SRA:  op_res = $signed(data1) >>> shamt;
      OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OP_SLTU: op_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
      OP_MUL:  op_multi = 1'b1;
`ifdef ITER_ALU_DIV_EN
      OP_DIV, OP_DIVU: op_multi = 1'b1;
`endif
      default: op_err = 1'b1;
    endcase
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept && op_multi),
    .kill       (flush),
`ifdef ITER_ALU_DIV_EN
    .div_op     ((select == OP_DIV) || (select == OP_DIVU)),
    .div_signed (select == OP_DIV),
`endif
    .a          (data1),
    .b          (data2),
    .done       (md_done),
    .res        (md_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (op_multi) begin
              state <= S_BUSY;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= op_res;
              err       <= op_err;
            end
          end
        end
        S_BUSY: begin
          if (md_done) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= md_res;
            err       <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, err;
  logic [3:0]  select;
  logic [31:0] data1, data2, result;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  iter_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .select    (select),
    .data1     (data1),
    .data2     (data2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its result; returns latency in
  // cycles counted from the accept edge.
  task automatic do_op(input string name, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output logic e,
                       output int lat);
    logic busy_ok;
    @(negedge clk);
    check({name, "_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; select = sel; data1 = a; data2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; select = 4'b0000; data1 = '0; data2 = '0;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    e   = err;
    check({name, "_ready_low_busy"}, 32'(busy_ok), 32'd1);
    check({name, "_ready_low_done"}, 32'(in_ready), 32'd0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({name, "_release"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  logic [31:0] r;
  logic        e;
  int          lat;
  int          cyc;
  logic        never;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    select = '0; data1 = '0; data2 = '0;

    vecs.push_back(vec_t'{"add_wrap", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1});
    vecs.push_back(vec_t'{"and",      4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1});
    vecs.push_back(vec_t'{"or",       4'b0001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1});
    vecs.push_back(vec_t'{"xor",      4'b0011, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1});
    vecs.push_back(vec_t'{"sll",      4'b0100, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1});
    vecs.push_back(vec_t'{"srl",      4'b0101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1});
    vecs.push_back(vec_t'{"sub_wrap", 4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1});
    vecs.push_back(vec_t'{"sra",      4'b0111, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1});
    vecs.push_back(vec_t'{"slt",      4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1});
    vecs.push_back(vec_t'{"sltu",     4'b1011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1});
    vecs.push_back(vec_t'{"mul_neg",  4'b1000, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, 1'b0, 33});
    vecs.push_back(vec_t'{"mul",      4'b1000, 32'h00012345, 32'h000003E8, 32'h0471C588, 1'b0, 33});
    vecs.push_back(vec_t'{"mul_ovf",  4'b1000, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 33});
    vecs.push_back(vec_t'{"undef_f",  4'b1111, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1});
    vecs.push_back(vec_t'{"undef_d",  4'b1101, 32'h00000005, 32'h00000006, 32'h00000000, 1'b1, 1});
`ifdef ITER_ALU_DIV_EN
    vecs.push_back(vec_t'{"div_neg",  4'b1001, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 33});
    vecs.push_back(vec_t'{"div_nd",   4'b1001, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33});
    vecs.push_back(vec_t'{"div_z",    4'b1001, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33});
    vecs.push_back(vec_t'{"div_nz",   4'b1001, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33});
    vecs.push_back(vec_t'{"div_ovf",  4'b1001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33});
    vecs.push_back(vec_t'{"divu",     4'b1100, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 33});
    vecs.push_back(vec_t'{"divu_big", 4'b1100, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 1'b0, 33});
    vecs.push_back(vec_t'{"divu_z",   4'b1100, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33});
`else
    vecs.push_back(vec_t'{"div_off",  4'b1001, 32'hFFFFFFF9, 32'h00000002, 32'h00000000, 1'b1, 1});
    vecs.push_back(vec_t'{"divu_off", 4'b1100, 32'h00000064, 32'h00000007, 32'h00000000, 1'b1, 1});
`endif

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors
    foreach (vecs[i]) begin
      do_op(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b, r, e, lat);
      check({vecs[i].name, "_result"}, r, vecs[i].res);
      check({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].err));
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result held 10 cycles; a competing request is ignored
    @(negedge clk);
    in_valid = 1'b1; select = 4'b0010; data1 = 32'd3; data2 = 32'd4;
    @(posedge clk); #1;
    select = 4'b0011; data1 = 32'hAAAA5555; data2 = 32'h0000FFFF;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    never = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (result !== 32'd7 || out_valid !== 1'b1 || in_ready !== 1'b0 || err !== 1'b0)
        never = 1'b0;
      @(posedge clk); #1;
    end
    check("hold_stable", 32'(never), 32'd1);
    check("hold_result", result, 32'd7);
    in_valid = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("hold_release", 32'({out_valid, in_ready}), 32'b01);

    // Flush on the same edge as a request: nothing accepted
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; select = 4'b0010; data1 = 32'd1; data2 = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_acc_ready", 32'(in_ready), 32'd1);
    never = 1'b1;
    repeat (3) begin
      if (out_valid) never = 1'b0;
      @(posedge clk); #1;
    end
    check("flush_acc_no_out", 32'(never), 32'd1);

    // Flush during BUSY cycle 5 of a multiply
    @(negedge clk);
    in_valid = 1'b1; select = 4'b1000; data1 = 32'd5; data2 = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy_ready", 32'(in_ready), 32'd1);
    never = 1'b1;
    repeat (40) begin
      if (out_valid) never = 1'b0;
      @(posedge clk); #1;
    end
    check("flush_busy_no_out", 32'(never), 32'd1);

    // Multiplier restarts cleanly after a flush
    do_op("mul_after_flush", 4'b1000, 32'd1234, 32'd5678, r, e, lat);
    check("mul_after_flush_result", r, 32'd7006652);
    check("mul_after_flush_latency", 32'(lat), 32'd33);

    // Reset during BUSY cycle 7
    @(negedge clk);
    in_valid = 1'b1; select = 4'b1000; data1 = 32'd9; data2 = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("rst_busy_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_busy_ready", 32'(in_ready), 32'd1);
    never = 1'b1;
    repeat (40) begin
      if (out_valid) never = 1'b0;
      @(posedge clk); #1;
    end
    check("rst_busy_no_out", 32'(never), 32'd1);

    do_op("mul_after_rst", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, r, e, lat);
    check("mul_after_rst_result", r, 32'h00000001);
    check("mul_after_rst_latency", 32'(lat), 32'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
